chacha_block_scheduler: RTL and testbench
=========================================

CHACHA_BLOCK_SCHEDULER -- requirements
Module: chacha_block_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of block-count request and index.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64: max WAIT_BF cycles before error (only with the Configuration macro).
REQ-003 SHALL have ports: clk, input, 1, single clock; all logic on posedge clk.
REQ-004 SHALL have ports: rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports: start, input, 1, request for a run of keystream blocks.
REQ-006 SHALL have ports: init_counter, input, 32, block counter of first block.
REQ-007 SHALL have ports: num_blocks, input, CNT_W, blocks to produce.
REQ-008 SHALL have ports: bf_block, output, 32, counter word driven to block function Block input.
REQ-009 SHALL have ports: bf_load, output, 1, one-cycle pulse that loads the block function matrix.
REQ-010 SHALL have ports: bf_ready, input, 1, block function reports finished block.
REQ-011 SHALL have ports: ks_valid, output, 1, keystream block available to serializer.
REQ-012 SHALL have ports: ks_ready, input, 1, serializer accepts block.
REQ-013 SHALL have ports: ks_index, output, CNT_W, zero-based index of the offered block.
REQ-014 SHALL have ports: busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have ports: done, output, 1, one-cycle pulse at run completion.
REQ-016 SHALL have ports: err, output, 1, sticky error flag.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WAIT_BF, HOLD, DONE, ERR.
REQ-018 IDLE + start: latch init_counter into bf_block and num_blocks into remaining count, clear ks_index and err, go to LOAD; start with num_blocks=0 goes straight to DONE.
REQ-019 LOAD: assert bf_load for exactly one cycle, go to WAIT_BF; bf_block stable from LOAD until block is accepted.
REQ-020 WAIT_BF: bf_ready high -> HOLD next cycle; bf_ready in any other state is ignored.
REQ-021 HOLD: ks_valid high; ks_valid SHALL NOT drop and ks_index SHALL NOT change until ks_valid&&ks_ready.
REQ-022 On acceptance with remaining=1 -> DONE; otherwise remaining-1, ks_index+1, bf_block+1, -> LOAD.
REQ-023 Latency: start to bf_load = 1 cycle; bf_ready to ks_valid = 1 cycle; ks_ready acceptance to next bf_load = 1 cycle.
REQ-024 Counter wrap: acceptance with bf_block=32'hFFFFFFFF and remaining>1 -> ERR, no wrap to 0, no further bf_load.
REQ-025 DONE: done=1 for one cycle, -> IDLE.
REQ-026 ERR: err=1, busy=1, remains in ERR until start, which is handled as in IDLE (err cleared).
REQ-027 start while in LOAD, WAIT_BF, HOLD or DONE SHALL be ignored.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, bf_block=0, ks_index=0, remaining=0, and all 1-bit outputs to 0, including mid-run; first start after release behaves as from power-up.

Configuration
REQ-029 Macro CHACHA_SCHED_TIMEOUT_EN defined: wait counter clears on WAIT_BF entry; TIMEOUT_CYC cycles in WAIT_BF without bf_ready -> ERR.
REQ-030 Macro absent: no wait counter; WAIT_BF waits indefinitely; err set only by counter wrap.

Verification
REQ-031 start, init_counter=1, num_blocks=3, bf_ready 10 cycles after each bf_load, ks_ready=1 -> bf_block 1,2,3; ks_index 0,1,2; one done pulse; err=0.
REQ-032 num_blocks=2, ks_ready held low 5 cycles in HOLD -> ks_valid/ks_index/bf_block stable 5 cycles; no second bf_load until acceptance.
REQ-033 init_counter=32'hFFFFFFFE, num_blocks=3 -> blocks FFFFFFFE, FFFFFFFF accepted, then err=1, no third bf_load, no done.
REQ-034 rst low during WAIT_BF of block 1 of 4 -> outputs 0 immediately; new start with num_blocks=1 -> single clean block, done.
REQ-035 With CHACHA_SCHED_TIMEOUT_EN, TIMEOUT_CYC=64, bf_ready never asserted -> err=1 after 64 WAIT_BF cycles; without macro -> still WAIT_BF after 1000 cycles.

Source files
------------

// File: rtl/chacha_block_scheduler.sv
// ChaCha block scheduler: sequences a run of keystream blocks through an external
// block function. It hands each block counter to the block function, waits for the
// finished block, then offers that block to the serializer until it is accepted.
// Optional feature: define CHACHA_SCHED_TIMEOUT_EN to bound the wait for bf_ready_i.
module chacha_block_scheduler #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      init_counter_i,
    input  logic [CNT_W-1:0] num_blocks_i,
    output logic [31:0]      bf_block_o,
    output logic             bf_load_o,
    input  logic             bf_ready_i,
    output logic             ks_valid_o,
    input  logic             ks_ready_i,
    output logic [CNT_W-1:0] ks_index_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitBf,
        StHold,
        StDone,
        StErr
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      bf_block_q, bf_block_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] ks_index_q, ks_index_d;
    logic             err_q, err_d;

`ifdef CHACHA_SCHED_TIMEOUT_EN
    localparam int unsigned WaitW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
`else
    // Timeout limit has no effect when the wait counter is not built.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            bf_block_q  <= '0;
            remaining_q <= '0;
            ks_index_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bf_block_q  <= bf_block_d;
            remaining_q <= remaining_d;
            ks_index_q  <= ks_index_d;
            err_q       <= err_d;
        end
    end

`ifdef CHACHA_SCHED_TIMEOUT_EN
    // Wait-cycle counter for the block function handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // Next-state logic: run sequencing, counter advance and error detection.
    always_comb begin
        state_d     = state_q;
        bf_block_d  = bf_block_q;
        remaining_d = remaining_q;
        ks_index_d  = ks_index_q;
        err_d       = err_q;
`ifdef CHACHA_SCHED_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            // ERR accepts a new run exactly like IDLE does.
            StIdle, StErr: begin
                if (start_i) begin
                    bf_block_d  = init_counter_i;
                    remaining_d = num_blocks_i;
                    ks_index_d  = '0;
                    err_d       = 1'b0;
                    state_d     = (num_blocks_i == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                state_d = StWaitBf;
`ifdef CHACHA_SCHED_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            StWaitBf: begin
                if (bf_ready_i) begin
                    state_d = StHold;
                end else begin
`ifdef CHACHA_SCHED_TIMEOUT_EN
                    if (wait_cnt_q == WaitW'(TIMEOUT_CYC - 1)) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
`endif
                end
            end
            StHold: begin
                if (ks_ready_i) begin
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end else if (bf_block_q == 32'hFFFF_FFFF) begin
                        // Next block would reuse counter 0: refuse to wrap.
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                        ks_index_d  = ks_index_q + 1'b1;
                        bf_block_d  = bf_block_q + 32'd1;
                        state_d     = StLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded directly from the registered state.
    always_comb begin
        bf_block_o = bf_block_q;
        ks_index_o = ks_index_q;
        bf_load_o  = (state_q == StLoad);
        ks_valid_o = (state_q == StHold);
        busy_o     = (state_q != StIdle);
        done_o     = (state_q == StDone);
        err_o      = err_q;
    end

endmodule

// File: tb/tb_chacha_block_scheduler.sv
// Self-checking bench for chacha_block_scheduler: randomized runs compared against
// a run-level model (which counters get produced, whether the run ends in done or err).
module tb_chacha_block_scheduler;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      init_counter = '0;
    logic [CNT_W-1:0] num_blocks = '0;
    logic             bf_ready = 1'b0;
    logic             ks_ready = 1'b0;
    logic [31:0]      bf_block;
    logic             bf_load;
    logic             ks_valid;
    logic [CNT_W-1:0] ks_index;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chacha_block_scheduler #(
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .init_counter_i(init_counter),
        .num_blocks_i  (num_blocks),
        .bf_block_o    (bf_block),
        .bf_load_o     (bf_load),
        .bf_ready_i    (bf_ready),
        .ks_valid_o    (ks_valid),
        .ks_ready_i    (ks_ready),
        .ks_index_o    (ks_index),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bf_block, ks_index, bf_load, ks_valid, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h/%0h/%b%b%b%b%b exp=all zero",
                     bf_block, ks_index, bf_load, ks_valid, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy got=%b exp=0", busy);
        end
    endtask

    // One complete run against the model: counters c, c+1, ... until n blocks are
    // accepted, or until the counter FFFFFFFF is accepted with more still requested.
    task automatic run_check(input logic [31:0] c, input int n, input int dmin, input int dmax,
                             input int ready_pct, input bit noise, input string name);
        longint unsigned top;
        int              exp_blocks;
        bit              exp_err;
        int              loads = 0, accepted = 0, dones = 0, cyc = 0, delay_left = 0;
        int              bound;
        bit              waiting = 0, finished = 0, saw_err = 0;
        logic [31:0]     eb;

        top = 64'(c) + 64'(n) - 64'd1;
        if (n == 0) begin
            exp_blocks = 0;
            exp_err    = 0;
        end else if (top > 64'hFFFF_FFFF) begin
            exp_err    = 1;
            exp_blocks = int'(64'h1_0000_0000 - 64'(c));
        end else begin
            exp_err    = 0;
            exp_blocks = n;
        end
        bound = (n + 1) * (dmax + 60) + 20;

        @(negedge clk);
        start        = 1'b1;
        init_counter = c;
        num_blocks   = CNT_W'(n);
        while (!finished && cyc < bound) begin
            @(negedge clk);
            cyc++;
            start    = 1'b0;
            bf_ready = 1'b0;
            if (bf_load) begin
                loads++;
                eb = c + 32'(loads - 1);
                checks++;
                if (bf_block !== eb) begin
                    failures++;
                    $display("FAIL %s load_block got=%0h exp=%0h", name, bf_block, eb);
                end
                checks++;
                if (loads > exp_blocks) begin
                    failures++;
                    $display("FAIL %s extra_load got=%0d exp<=%0d", name, loads, exp_blocks);
                end
                waiting    = 1;
                delay_left = $urandom_range(dmax, dmin);
            end
            if (ks_valid) begin
                eb = c + 32'(accepted);
                checks++;
                if (ks_index !== CNT_W'(accepted) || bf_block !== eb) begin
                    failures++;
                    $display("FAIL %s offer got=%0d/%0h exp=%0d/%0h", name, ks_index, bf_block,
                             accepted, eb);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy got=%b exp=1", name, busy);
            end
            if (done) begin
                dones++;
                finished = 1;
            end
            if (err) begin
                saw_err  = 1;
                finished = 1;
            end
            if (!finished) begin
                if (waiting && !bf_load) begin
                    delay_left--;
                    if (delay_left <= 0) begin
                        bf_ready = 1'b1;
                        waiting  = 0;
                    end
                end else if (noise && !waiting) begin
                    bf_ready = ($urandom_range(3, 0) == 0);
                end
                ks_ready = ($urandom_range(99, 0) < ready_pct);
                if (ks_valid && ks_ready) accepted++;
                if (noise) begin
                    start        = ($urandom_range(2, 0) == 0);
                    init_counter = $urandom;
                    num_blocks   = CNT_W'($urandom);
                end
            end
        end
        start    = 1'b0;
        bf_ready = 1'b0;
        ks_ready = 1'b0;

        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s run_timeout got=unfinished exp=finished within %0d", name, bound);
        end
        checks++;
        if (accepted != exp_blocks || loads != exp_blocks) begin
            failures++;
            $display("FAIL %s block_count got=acc %0d load %0d exp=%0d", name, accepted, loads,
                     exp_blocks);
        end
        checks++;
        if (dones != (exp_err ? 0 : 1) || saw_err != exp_err) begin
            failures++;
            $display("FAIL %s ending got=done %0d err %0d exp=done %0d err %0d", name, dones,
                     saw_err, exp_err ? 0 : 1, exp_err);
        end
        @(negedge clk);
        checks++;
        if (exp_err) begin
            if ({busy, err, done, bf_load} !== 4'b1100) begin
                failures++;
                $display("FAIL %s err_hold got=%b exp=1100", name, {busy, err, done, bf_load});
            end
        end else if ({busy, err, done, bf_load} !== 4'b0000) begin
            failures++;
            $display("FAIL %s back_to_idle got=%b exp=0000", name, {busy, err, done, bf_load});
        end
    endtask

    task automatic test_basic();
        run_check(32'd1, 3, 10, 10, 100, 0, "basic");
        run_check(32'h1234_5678, 0, 1, 1, 100, 0, "zero_blocks");
    endtask

    task automatic test_hold_stall();
        logic [31:0] c;
        int          cyc;
        c = $urandom_range(32'h7FFF_FFFF, 0);
        @(negedge clk);
        start        = 1'b1;
        init_counter = c;
        num_blocks   = CNT_W'(2);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bf_load !== 1'b1 || bf_block !== c) begin
            failures++;
            $display("FAIL stall start_latency got=%b/%0h exp=1/%0h", bf_load, bf_block, c);
        end
        @(negedge clk);
        bf_ready = 1'b1;
        @(negedge clk);
        bf_ready = 1'b0;
        checks++;
        if (ks_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall ready_latency got=%b exp=1", ks_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({ks_valid, bf_load} !== 2'b10 || ks_index !== '0 || bf_block !== c) begin
                failures++;
                $display("FAIL stall hold_%0d got=%b/%0d/%0h exp=10/0/%0h", i,
                         {ks_valid, bf_load}, ks_index, bf_block, c);
            end
        end
        ks_ready = 1'b1;
        @(negedge clk);
        ks_ready = 1'b0;
        checks++;
        if (bf_load !== 1'b1 || bf_block !== c + 32'd1 || ks_index !== CNT_W'(1)) begin
            failures++;
            $display("FAIL stall next_load got=%b/%0h/%0d exp=1/%0h/1", bf_load, bf_block,
                     ks_index, c + 32'd1);
        end
        bf_ready = 1'b1;
        ks_ready = 1'b1;
        cyc      = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        bf_ready = 1'b0;
        ks_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL stall done got=%b exp=1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        run_check(32'hFFFF_FFFE, 3, 2, 4, 100, 0, "wrap");
        run_check(32'hFFFF_FFFF, 1, 1, 3, 100, 0, "top_single");
        run_check(32'hFFFF_FFF0, 2, 1, 3, 100, 0, "after_err");
    endtask

    task automatic test_random();
        logic [31:0] c;
        int          n;
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(3, 0) == 0) c = 32'hFFFF_FFFF - $urandom_range(3, 0);
            else c = $urandom;
            n = $urandom_range(6, 0);
            run_check(c, n, 1, $urandom_range(8, 1), $urandom_range(100, 30), 1, "random");
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start        = 1'b1;
        init_counter = 32'hA5A5_0000;
        num_blocks   = CNT_W'(4);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bf_block, ks_index, bf_load, ks_valid, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL midrun_reset got=%0h/%0h/%b%b%b%b%b exp=all zero",
                     bf_block, ks_index, bf_load, ks_valid, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_check($urandom, 1, 1, 5, 100, 0, "after_reset");
    endtask

    task automatic test_wait_forever();
        int cyc;
        @(negedge clk);
        start        = 1'b1;
        init_counter = 32'd7;
        num_blocks   = CNT_W'(1);
        @(negedge clk);
        start = 1'b0;
`ifdef CHACHA_SCHED_TIMEOUT_EN
        cyc = 0;
        while (!err && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (err !== 1'b1 || cyc != 65) begin
            failures++;
            $display("FAIL timeout got=err %b after %0d exp=err 1 after 65", err, cyc);
        end
`else
        cyc = 0;
        repeat (1000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({busy, ks_valid, err, bf_load, done} !== 5'b10000) begin
            failures++;
            $display("FAIL no_timeout got=%b after %0d exp=10000", {busy, ks_valid, err,
                     bf_load, done}, cyc);
        end
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_wrap();
        test_random();
        test_reset_midrun();
        test_wait_forever();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
